// File: rtl/multicycle_addsub.sv
// ============================================================================
// Module      : multicycle_addsub
// Description : Multi-cycle WIDTH-bit adder/subtractor, CHUNK bits per clock
//               through one ripple stage, valid/ready on both sides.
//               Optional macro ADDSUB_OVF_EN enables signed-overflow output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_addsub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int c_CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK;
    localparam int c_NCHUNK     = WIDTH / c_CHUNK_SAFE;
    localparam int c_CW         = (c_NCHUNK > 1) ? $clog2(c_NCHUNK) : 1;

    generate
        if ((CHUNK < 1) || ((WIDTH % c_CHUNK_SAFE) != 0)) begin : g_bad_cfg
            $error("multicycle_addsub: CHUNK must be >= 1 and divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [c_CW-1:0]   r_cnt;
    logic              r_carry;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_s;
    logic              r_cout;
    logic              r_in_ready;
    logic              r_out_valid;

    logic [CHUNK-1:0]  w_a_chunk;
    logic [CHUNK-1:0]  w_b_chunk;
    logic [CHUNK:0]    w_full;
    logic              w_last;

    always_comb begin
        w_a_chunk = '0;
        w_b_chunk = '0;
        for (int k = 0; k < c_NCHUNK; k++) begin
            if (r_cnt == c_CW'(k)) begin
                w_a_chunk = r_a[k*CHUNK +: CHUNK];
                w_b_chunk = r_b[k*CHUNK +: CHUNK];
            end
        end
    end

    assign w_full = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
    assign w_last = (r_cnt == c_CW'(c_NCHUNK - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_s         <= '0;
            r_cout      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtract is a + ~b + 1, with the borrow-in removing that +1.
                        r_a        <= a;
                        r_b        <= sub ? ~b : b;
                        r_carry    <= sub ? ~cin : cin;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    for (int k = 0; k < c_NCHUNK; k++) begin
                        if (r_cnt == c_CW'(k)) begin
                            r_s[k*CHUNK +: CHUNK] <= w_full[CHUNK-1:0];
                        end
                    end
                    r_carry <= w_full[CHUNK];
                    r_cnt   <= r_cnt + c_CW'(1);
                    if (w_last) begin
                        r_cout      <= w_full[CHUNK];
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

`ifdef ADDSUB_OVF_EN
    logic r_cmsb;
    logic w_cmsb;

    // Carry into the MSB recovered from the MSB sum bit of the final chunk.
    assign w_cmsb = w_a_chunk[CHUNK-1] ^ w_b_chunk[CHUNK-1] ^ w_full[CHUNK-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmsb <= 1'b0;
        end else if ((r_state == RUN) && w_last) begin
            r_cmsb <= w_cmsb;
        end
    end

    assign ovf = r_cmsb ^ r_cout;
`else
    assign ovf = 1'b0;
`endif

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign s         = r_s;
    assign cout      = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_addsub.sv
// ============================================================================
// Module      : tb_multicycle_addsub
// Description : Scoreboard bench for multicycle_addsub (32/8 and 8/8 builds).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_addsub;

`ifdef ADDSUB_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, sub, cin, out_valid, out_ready, cout, ovf;
    logic [31:0] a, b, s;
    logic        in_valid8, in_ready8, sub8, cin8, out_valid8, out_ready8, cout8, ovf8;
    logic [7:0]  a8, b8, s8;

    multicycle_addsub #(.WIDTH(32), .CHUNK(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid),
        .out_ready(out_ready), .s(s), .cout(cout), .ovf(ovf)
    );

    multicycle_addsub #(.WIDTH(8), .CHUNK(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .sub(sub8), .cin(cin8), .out_valid(out_valid8),
        .out_ready(out_ready8), .s(s8), .cout(cout8), .ovf(ovf8)
    );

    typedef struct packed {
        logic [31:0] s;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitors: pop and compare on every result handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q32.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result32 actual=%0h required=none", s);
            end else begin
                exp_t e;
                e = q32.pop_front();
                chk("s32", {32'h0, s}, {32'h0, e.s});
                chk("cout32", {63'h0, cout}, {63'h0, e.cout});
                chk("ovf32", {63'h0, ovf}, {63'h0, e.ovf});
            end
        end
        if (rst_n && out_valid8 && out_ready8) begin
            if (q8.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result8 actual=%0h required=none", s8);
            end else begin
                exp_t e;
                e = q8.pop_front();
                chk("s8", {56'h0, s8}, {56'h0, e.s[7:0]});
                chk("cout8", {63'h0, cout8}, {63'h0, e.cout});
                chk("ovf8", {63'h0, ovf8}, {63'h0, e.ovf});
            end
        end
    end

    // Issue one 32-bit op; optionally complete the handshake with out_ready=1.
    task automatic do_op(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                         input logic icin, input logic [31:0] es, input logic ec,
                         input logic eo, input bit finish);
        int n;
        @(negedge clk);
        chk("in_ready_idle", {63'h0, in_ready}, 64'h1);
        a = ia; b = ib; sub = isub; cin = icin; in_valid = 1'b1;
        q32.push_back('{s: es, cout: ec, ovf: eo});
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        chk("latency32", 64'(n), 64'd4);
        if (finish) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            chk("out_valid_drop", {63'h0, out_valid}, 64'h0);
            chk("in_ready_after", {63'h0, in_ready}, 64'h1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0; out_ready = 1'b1;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0; cin8 = 1'b0; out_ready8 = 1'b1;
        #12;
        chk("rst_s", {32'h0, s}, 64'h0);
        chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
        chk("rst_in_ready", {63'h0, in_ready}, 64'h1);
        chk("rst_cout_ovf", {62'h0, cout, ovf}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        do_op(32'd5, 32'd7, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
        do_op(32'd7, 32'd5, 1'b1, 1'b1, 32'h1, 1'b1, 1'b0, 1'b1);
        do_op(32'h8000_0000, 32'h1, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, OVF_ON, 1'b1);

        // Backpressure with a competing request on the input.
        out_ready = 1'b0;
        do_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, OVF_ON, 1'b0);
        a = 32'h1234_5678; b = 32'h1111_1111; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("hold_out_valid", {63'h0, out_valid}, 64'h1);
            chk("hold_s", {32'h0, s}, 64'h8000_0000);
            chk("hold_cout_ovf", {62'h0, cout, ovf}, {62'h0, 1'b0, OVF_ON});
            chk("hold_in_ready", {63'h0, in_ready}, 64'h0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_out_valid", {63'h0, out_valid}, 64'h0);
        chk("release_in_ready", {63'h0, in_ready}, 64'h1);
        repeat (6) @(posedge clk);
        #1 chk("no_stray_result", {63'h0, out_valid}, 64'h0);

        // Abort after two RUN edges.
        @(negedge clk);
        a = 32'hAAAA_AAAA; b = 32'h5555_5555; sub = 1'b0; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_s", {32'h0, s}, 64'h0);
        chk("abort_out_valid", {63'h0, out_valid}, 64'h0);
        chk("abort_in_ready", {63'h0, in_ready}, 64'h1);
        chk("abort_cout_ovf", {62'h0, cout, ovf}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0, 1'b1);

        // Single-chunk build.
        begin
            int n;
            @(negedge clk);
            a8 = 8'h80; b8 = 8'h80; sub8 = 1'b0; cin8 = 1'b1; in_valid8 = 1'b1;
            q8.push_back('{s: 32'h01, cout: 1'b1, ovf: OVF_ON});
            @(posedge clk);
            #1 in_valid8 = 1'b0;
            n = 0;
            while (!out_valid8 && n < 20) begin
                @(posedge clk);
                #1 n++;
            end
            chk("latency8", 64'(n), 64'd1);
            repeat (2) @(posedge clk);
        end

        #1;
        chk("queue32_empty", 64'(q32.size()), 64'd0);
        chk("queue8_empty", 64'(q8.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
